// File: rtl/audio_pkg.sv
// Shared widths, FSM state encoding and per-channel shift lookup for the audio filter scheduler.
package audio_pkg;

  localparam int unsigned NUM_CH   = 4;
  localparam int unsigned SAMPLE_W = 16;
  localparam int unsigned FRAC_W   = 8;
  localparam int unsigned ACC_W    = 24;
  localparam int unsigned CH_IDX_W = 2;
  localparam int unsigned SHIFT_W  = 4;
  localparam int unsigned MIX_W    = SAMPLE_W + CH_IDX_W;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    MIX  = 2'd2,
    DONE = 2'd3
  } state_e;

  // Picks the 4-bit IIR shift for one channel out of the packed SHIFTS word.
  function automatic logic [SHIFT_W-1:0] shift_of(input logic [NUM_CH*SHIFT_W-1:0] shifts,
                                                  input logic [CH_IDX_W-1:0] idx);
    logic [SHIFT_W-1:0] s;
    case (idx)
      2'd0:    s = shifts[3:0];
      2'd1:    s = shifts[7:4];
      2'd2:    s = shifts[11:8];
      default: s = shifts[15:12];
    endcase
    return s;
  endfunction

endpackage

// File: rtl/audio_iir_step.sv
// One first-order IIR step: acc + (({in,8'h00} - acc) >>> shift), purely combinational.
module audio_iir_step
  import audio_pkg::*;
(
  input  logic [SAMPLE_W-1:0] in,
  input  logic [ACC_W-1:0]    acc,
  input  logic [SHIFT_W-1:0]  shift,
  output logic [ACC_W-1:0]    acc_next
);

  logic signed [ACC_W:0] d;

  always_comb begin
    d        = $signed({1'b0, in, 8'h00}) - $signed({1'b0, acc});
    // The accumulator only moves toward the target, so the 24-bit result cannot wrap.
    acc_next = ACC_W'($signed({1'b0, acc}) + (d >>> shift));
  end

endmodule

// File: rtl/audio_filter_sched.sv
// Four-channel IIR filter scheduler sharing one step unit, with a mixed output.
// Define AUDIO_SCHED_SAT_EN to saturate the mix sum instead of averaging it.
module audio_filter_sched
  import audio_pkg::*;
#(
  parameter logic [NUM_CH*SHIFT_W-1:0] SHIFTS = 16'h2222
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         clk_3MHz_en,
  input  logic                         sound_enable,
  input  logic [NUM_CH*SAMPLE_W-1:0]   ch_in,
  input  logic                         overrun_clr,
  output logic [NUM_CH*SAMPLE_W-1:0]   ch_out,
  output logic [SAMPLE_W-1:0]          mix_out,
  output logic                         out_valid,
  output logic                         busy,
  output logic                         overrun
);

  state_e                state_q, state_d;
  logic [CH_IDX_W-1:0]   ch_idx_q, ch_idx_d;
  logic [SAMPLE_W-1:0]   snap_q [NUM_CH];
  logic [SAMPLE_W-1:0]   snap_d [NUM_CH];
  logic [ACC_W-1:0]      acc_q  [NUM_CH];
  logic [ACC_W-1:0]      acc_d  [NUM_CH];
  logic [SAMPLE_W-1:0]   mix_pend_q, mix_pend_d;
  logic [NUM_CH*SAMPLE_W-1:0] ch_out_d;
  logic [SAMPLE_W-1:0]   mix_out_d;
  logic                  out_valid_d, busy_d, overrun_d;

  logic [SAMPLE_W-1:0]   step_in;
  logic [ACC_W-1:0]      step_acc;
  logic [SHIFT_W-1:0]    step_shift;
  logic [ACC_W-1:0]      step_acc_next;
  logic [MIX_W-1:0]      mix_sum;
  logic [SAMPLE_W-1:0]   mix_val;

  assign step_in    = snap_q[ch_idx_q];
  assign step_acc   = acc_q[ch_idx_q];
  assign step_shift = shift_of(SHIFTS, ch_idx_q);

  audio_iir_step u_step (
    .in       (step_in),
    .acc      (step_acc),
    .shift    (step_shift),
    .acc_next (step_acc_next)
  );

  // Mix is taken from the freshly updated accumulators so it matches the ch_out published with it.
  always_comb begin
    mix_sum = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      mix_sum = mix_sum + MIX_W'(acc_q[i][ACC_W-1:FRAC_W]);
    end
`ifdef AUDIO_SCHED_SAT_EN
    mix_val = (mix_sum > MIX_W'(18'h0FFFF)) ? 16'hFFFF : SAMPLE_W'(mix_sum);
`else
    mix_val = SAMPLE_W'(mix_sum >> 2);
`endif
  end

  // Next-state and output logic.
  always_comb begin
    state_d     = state_q;
    ch_idx_d    = ch_idx_q;
    snap_d      = snap_q;
    acc_d       = acc_q;
    mix_pend_d  = mix_pend_q;
    ch_out_d    = ch_out;
    mix_out_d   = mix_out;
    out_valid_d = 1'b0;
    overrun_d   = overrun;

    case (state_q)
      IDLE: begin
        if (clk_3MHz_en) begin
          for (int i = 0; i < NUM_CH; i++) begin
            snap_d[i] = ch_in[i*SAMPLE_W +: SAMPLE_W];
          end
          ch_idx_d = '0;
          state_d  = RUN;
        end
      end
      RUN: begin
        acc_d[ch_idx_q] = step_acc_next;
        ch_idx_d        = ch_idx_q + CH_IDX_W'(1);
        if (ch_idx_q == CH_IDX_W'(NUM_CH - 1)) begin
          state_d = MIX;
        end
      end
      MIX: begin
        mix_pend_d = sound_enable ? mix_val : '0;
        state_d    = DONE;
      end
      DONE: begin
        for (int i = 0; i < NUM_CH; i++) begin
          ch_out_d[i*SAMPLE_W +: SAMPLE_W] = acc_q[i][ACC_W-1:FRAC_W];
        end
        mix_out_d   = mix_pend_q;
        out_valid_d = 1'b1;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Clear first so a coincident overrun wins.
    if (overrun_clr) begin
      overrun_d = 1'b0;
    end
    if (clk_3MHz_en && (state_q != IDLE)) begin
      overrun_d = 1'b1;
    end

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      ch_idx_q   <= '0;
      mix_pend_q <= '0;
      ch_out     <= '0;
      mix_out    <= '0;
      out_valid  <= 1'b0;
      busy       <= 1'b0;
      overrun    <= 1'b0;
      for (int i = 0; i < NUM_CH; i++) begin
        snap_q[i] <= '0;
        acc_q[i]  <= '0;
      end
    end else begin
      state_q    <= state_d;
      ch_idx_q   <= ch_idx_d;
      mix_pend_q <= mix_pend_d;
      ch_out     <= ch_out_d;
      mix_out    <= mix_out_d;
      out_valid  <= out_valid_d;
      busy       <= busy_d;
      overrun    <= overrun_d;
      for (int i = 0; i < NUM_CH; i++) begin
        snap_q[i] <= snap_d[i];
        acc_q[i]  <= acc_d[i];
      end
    end
  end

endmodule

// File: tb/tb_audio_filter_sched.sv
// Directed bench: dut_a uses the default shifts, dut_b uses shift 0 (one-frame identity).
module tb_audio_filter_sched;

  logic        clk;
  logic        rst;
  logic        clk_3MHz_en;
  logic        sound_enable;
  logic [63:0] ch_in;
  logic        overrun_clr;

  logic [63:0] ch_out_a, ch_out_b;
  logic [15:0] mix_out_a, mix_out_b;
  logic        ov_a, ov_b;
  logic        busy_a, busy_b;
  logic        overrun_a, overrun_b;

  int checks;
  int failures;

`ifdef AUDIO_SCHED_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  audio_filter_sched #(.SHIFTS(16'h2222)) dut_a (
    .clk          (clk),
    .rst          (rst),
    .clk_3MHz_en  (clk_3MHz_en),
    .sound_enable (sound_enable),
    .ch_in        (ch_in),
    .overrun_clr  (overrun_clr),
    .ch_out       (ch_out_a),
    .mix_out      (mix_out_a),
    .out_valid    (ov_a),
    .busy         (busy_a),
    .overrun      (overrun_a)
  );

  audio_filter_sched #(.SHIFTS(16'h0000)) dut_b (
    .clk          (clk),
    .rst          (rst),
    .clk_3MHz_en  (clk_3MHz_en),
    .sound_enable (sound_enable),
    .ch_in        (ch_in),
    .overrun_clr  (overrun_clr),
    .ch_out       (ch_out_b),
    .mix_out      (mix_out_b),
    .out_valid    (ov_b),
    .busy         (busy_b),
    .overrun      (overrun_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Strobe one frame and wait for out_valid; returns at the negedge where it is high.
  task automatic do_frame(input logic [63:0] din, input logic se);
    int cyc;
    @(negedge clk);
    ch_in = din; sound_enable = se; clk_3MHz_en = 1'b1;
    @(negedge clk);
    clk_3MHz_en = 1'b0;
    cyc = 1;
    while (!ov_b && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    chk("latency", 64'(cyc), 64'd7);
    chk("valid_a", 64'(ov_a), 64'd1);
  endtask

  typedef struct {
    logic [63:0] ch_in;
    logic        se;
    logic [63:0] exp_ch;
    logic [15:0] exp_avg;
    logic [15:0] exp_sat;
  } vec_t;

  vec_t vecs [5];

  initial begin
    int cyc, pulses, first;
    checks = 0; failures = 0;
    rst = 1'b1; clk_3MHz_en = 1'b0; sound_enable = 1'b1; ch_in = '0; overrun_clr = 1'b0;

    vecs[0] = '{64'h8000_8000_8000_8000, 1'b1, 64'h8000_8000_8000_8000, 16'h8000, 16'hFFFF};
    vecs[1] = '{64'h1234_1234_1234_1234, 1'b0, 64'h1234_1234_1234_1234, 16'h0000, 16'h0000};
    vecs[2] = '{64'h0004_0003_0002_0001, 1'b1, 64'h0004_0003_0002_0001, 16'h0002, 16'h000A};
    vecs[3] = '{64'h4000_3000_2000_1000, 1'b1, 64'h4000_3000_2000_1000, 16'h2800, 16'hA000};
    vecs[4] = '{64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 16'hFFFF, 16'hFFFF};

    repeat (3) @(negedge clk);
    chk("rst_ch_out", ch_out_a, 64'h0);
    chk("rst_mix", 64'(mix_out_a), 64'h0);
    chk("rst_flags", {61'h0, ov_a, busy_a, overrun_a}, 64'h0);
    rst = 1'b0;

    // Step response with shift 2 on channel 0.
    do_frame(64'h0000_0000_0000_4000, 1'b1);
    chk("step_f1", ch_out_a, 64'h0000_0000_0000_1000);
    chk("step_f1_mix", 64'(mix_out_a), SAT ? 64'h1000 : 64'h0400);
    do_frame(64'h0000_0000_0000_4000, 1'b1);
    chk("step_f2", ch_out_a, 64'h0000_0000_0000_1C00);
    repeat (4) @(negedge clk);
    chk("hold_ch_out", ch_out_a, 64'h0000_0000_0000_1C00);
    chk("valid_single", 64'(ov_a), 64'd0);

    // Reset in the middle of RUN clears everything at once.
    @(negedge clk);
    clk_3MHz_en = 1'b1;
    @(negedge clk);
    clk_3MHz_en = 1'b0;
    @(negedge clk);
    chk("busy_run", 64'(busy_a), 64'd1);
    rst = 1'b1;
    #1;
    chk("midrst_ch_out", ch_out_a, 64'h0);
    chk("midrst_mix", 64'(mix_out_a), 64'h0);
    chk("midrst_flags", {61'h0, ov_a, busy_a, overrun_a}, 64'h0);
    @(negedge clk);
    rst = 1'b0;
    do_frame(64'h0000_0000_0000_4000, 1'b1);
    chk("postrst_f1", ch_out_a, 64'h0000_0000_0000_1000);

    // Second strobe at cycle 3 is ignored and flags overrun.
    @(negedge clk);
    ch_in = 64'h8000_8000_8000_8000; sound_enable = 1'b1; clk_3MHz_en = 1'b1;
    @(negedge clk);
    clk_3MHz_en = 1'b0;
    @(negedge clk);
    @(negedge clk);
    clk_3MHz_en = 1'b1;
    @(negedge clk);
    clk_3MHz_en = 1'b0;
    cyc = 4; pulses = 0; first = 0;
    repeat (13) begin
      if (ov_b) begin
        pulses++;
        if (first == 0) first = cyc;
      end
      @(negedge clk);
      cyc++;
    end
    chk("ovr_first_valid", 64'(first), 64'd7);
    chk("ovr_pulses", 64'(pulses), 64'd1);
    chk("ovr_mix", 64'(mix_out_b), SAT ? 64'hFFFF : 64'h8000);
    chk("ovr_flag", {62'h0, overrun_a, overrun_b}, 64'h3);
    overrun_clr = 1'b1;
    @(negedge clk);
    overrun_clr = 1'b0;
    chk("ovr_clear", {62'h0, overrun_a, overrun_b}, 64'h0);

    // Clear and new overrun together: set wins.
    @(negedge clk);
    clk_3MHz_en = 1'b1;
    @(negedge clk);
    clk_3MHz_en = 1'b1; overrun_clr = 1'b1;
    @(negedge clk);
    clk_3MHz_en = 1'b0; overrun_clr = 1'b0;
    chk("ovr_set_wins", 64'(overrun_b), 64'd1);
    repeat (8) @(negedge clk);
    overrun_clr = 1'b1;
    @(negedge clk);
    overrun_clr = 1'b0;

    // Shift-0 vectors: ch_out equals input after one frame; mix averaged or saturated.
    for (int i = 0; i < 5; i++) begin
      do_frame(vecs[i].ch_in, vecs[i].se);
      chk($sformatf("vec%0d_ch_out", i), ch_out_b, vecs[i].exp_ch);
      chk($sformatf("vec%0d_mix", i), 64'(mix_out_b), 64'(SAT ? vecs[i].exp_sat : vecs[i].exp_avg));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/audio_filter_sched.md
AUDIO_FILTER_SCHED -- requirements
Module: audio_filter_sched

Interface
REQ-001 SHALL have parameter SHIFTS, default 16'h2222: four 4-bit IIR shift values; channel i uses SHIFTS[4i+3:4i], range 0..15.
REQ-002 SHALL have port clk  input  1  system clock; sole clock.
REQ-003 SHALL have port rst  input  1  reset; asynchronous, active-high.
REQ-004 SHALL have port clk_3MHz_en  input  1  one-cycle frame strobe.
REQ-005 SHALL have port sound_enable  input  1  1 = mix output live; 0 = mix output muted.
REQ-006 SHALL have port ch_in  input  64  four unsigned 16-bit samples; channel i is bits [16i+15:16i].
REQ-007 SHALL have port overrun_clr  input  1  clears the overrun flag.
REQ-008 SHALL have port ch_out  output  64  four filtered 16-bit channel samples, packed the same way as ch_in.
REQ-009 SHALL have port mix_out  output  16  mixed output sample.
REQ-010 SHALL have port out_valid  output  1  one-cycle pulse when ch_out and mix_out update.
REQ-011 SHALL have port busy  output  1  high while a frame is in progress.
REQ-012 SHALL have port overrun  output  1  sticky flag: a strobe arrived while busy.

Function
REQ-013 SHALL implement FSM states IDLE, RUN, MIX and DONE.
REQ-014 IDLE with clk_3MHz_en=1 SHALL snapshot all four ch_in words, set the channel index to 0 and go to RUN; busy SHALL be 1 from the next cycle.
REQ-015 RUN SHALL process exactly one channel per cycle in order 0,1,2,3 through the single shared step unit, then go to MIX.
REQ-016 Each channel SHALL keep a 24-bit accumulator acc (16 integer bits, 8 fraction bits), unsigned.
REQ-017 The step SHALL compute d = {in,8'h00} - acc as a 25-bit signed value, then acc <= acc + (d >>> shift), using an arithmetic shift.
REQ-018 ch_out for channel i SHALL be acc[23:8]; with shift=0, ch_out SHALL equal the sampled input after one frame.
REQ-019 MIX SHALL form the 18-bit unsigned sum of the four ch_out values and register mix_out per REQ-027/028.
REQ-020 If sound_enable=0 when MIX executes, mix_out SHALL be loaded with 0; the accumulators SHALL still update.
REQ-021 DONE SHALL assert out_valid for exactly one cycle and return to IDLE.
REQ-022 Latency SHALL be fixed: strobe in cycle t gives out_valid in cycle t+7 (1 IDLE + 4 RUN + MIX + DONE), independent of data.
REQ-023 A clk_3MHz_en strobe in any state other than IDLE SHALL be ignored and SHALL set overrun; a frame in progress SHALL not be disturbed.
REQ-024 If overrun_clr and a new overrun occur in the same cycle, overrun SHALL be 1 (set wins).
REQ-025 ch_out and mix_out SHALL hold their values between out_valid pulses.

Reset
REQ-026 When rst is asserted, including mid-frame, the block SHALL asynchronously go to IDLE and SHALL clear all accumulators, ch_out, mix_out, out_valid, busy and overrun to 0; the first strobe after rst deasserts SHALL start a full frame.

Configuration
REQ-027 With AUDIO_SCHED_SAT_EN defined, mix_out SHALL be the 18-bit sum saturated to 16'hFFFF.
REQ-028 Without AUDIO_SCHED_SAT_EN, mix_out SHALL be sum[17:2] (average of four), with no saturation logic compiled.

Structure
REQ-029 Shared package audio_pkg SHALL hold: NUM_CH=4, SAMPLE_W=16, FRAC_W=8, ACC_W=24, and the FSM state enum.
REQ-030 The step arithmetic (subtract, shift, add) SHALL be a combinational sub-module audio_iir_step, instantiated exactly once.

Verification
REQ-031 Step response: SHIFTS=16'h2222, ch0=0x4000, others 0 -> ch0 out 0x1000 after frame 1, 0x1C00 after frame 2; other channels stay 0.
REQ-032 Mixing: SHIFTS=0, all ch_in=0x8000, sound_enable=1 -> mix_out=0xFFFF with AUDIO_SCHED_SAT_EN, 0x8000 without.
REQ-033 Latency/overrun: strobe at cycle 0 and again at cycle 3 -> single out_valid at cycle 7, overrun=1; overrun_clr -> overrun=0.
REQ-034 Mute: sound_enable=0, SHIFTS=0, ch_in=0x1234 each -> mix_out=0, every ch_out=0x1234, out_valid still pulses.
REQ-035 Reset mid-frame: rst asserted in RUN after two frames with ch0=0x4000 -> all outputs 0 immediately; next frame with shift 2 gives ch0 out 0x1000.
